// File: rtl/mem_types_pkg.sv
// Shared types and geometry for the cache-line to memory-burst adaptor.
// The line and beat widths, the line-offset width and the FSM state encoding live here.
package mem_types_pkg;
   localparam int LINE_W      = 256;
   localparam int BURST_W     = 64;
   localparam int BURST_LEN   = 4;
   localparam int ADDR_W      = 32;
   localparam int OFFSET_BITS = $clog2(LINE_W / 8);
   localparam int CNT_W       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} adaptor_state_t;

   typedef logic [LINE_W-1:0]                 line_t;
   typedef logic [BURST_W-1:0]                burst_t;
   typedef logic [ADDR_W-1:0]                 addr_t;
   typedef logic [CNT_W-1:0]                  cnt_t;
   typedef logic [BURST_LEN-1:0][BURST_W-1:0] beats_t;

   function automatic addr_t line_align(input addr_t a);
      return {a[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
   endfunction
endpackage

// File: rtl/cacheline_adaptor_if.sv
// Bundles the cache-side and memory-side signals of the adaptor.
// The master modport is the adaptor; the slave modport is the cache and memory environment.
interface cacheline_adaptor_if;
   import mem_types_pkg::*;

   line_t  line_i;
   line_t  line_o;
   addr_t  address_i;
   logic   read_i;
   logic   write_i;
   logic   resp_o;
   burst_t burst_i;
   burst_t burst_o;
   addr_t  address_o;
   logic   read_o;
   logic   write_o;
   logic   resp_i;

   modport master (
      input  line_i, address_i, read_i, write_i, burst_i, resp_i,
      output line_o, resp_o, burst_o, address_o, read_o, write_o
   );

   modport slave (
      output line_i, address_i, read_i, write_i, burst_i, resp_i,
      input  line_o, resp_o, burst_o, address_o, read_o, write_o
   );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts a single-cycle cache line request into a BURST_LEN-beat memory burst.
// Beats are gathered into or served from a line buffer that is indexed by the beat count.
module cacheline_adaptor
   import mem_types_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   cacheline_adaptor_if.master bus
);

   if (BURST_LEN * BURST_W != LINE_W) begin : g_bad_geometry
      $error("cacheline_adaptor: LINE_W must equal BURST_LEN * BURST_W");
   end

   localparam cnt_t LAST_BEAT = cnt_t'(BURST_LEN - 1);

   adaptor_state_t state_q, state_d;
   cnt_t           cnt_q,   cnt_d;
   addr_t          addr_q,  addr_d;
   beats_t         buf_q,   buf_d;
   line_t          line_q,  line_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         buf_q   <= '0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         buf_q   <= buf_d;
         line_q  <= line_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      buf_d   = buf_q;
      line_d  = line_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            // Read takes priority if the cache ever raises both requests.
            if (bus.read_i) begin
               addr_d  = line_align(bus.address_i);
               state_d = RD;
            end else if (bus.write_i) begin
               addr_d  = line_align(bus.address_i);
               buf_d   = bus.line_i;
               state_d = WR;
            end
         end
         RD: begin
            if (bus.resp_i) begin
               buf_d[cnt_q] = bus.burst_i;
               cnt_d        = cnt_q + 1'b1;
               if (cnt_q == LAST_BEAT) begin
                  line_d  = buf_d;
                  state_d = DONE;
               end
            end
         end
         WR: begin
            if (bus.resp_i) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_BEAT) state_d = DONE;
            end
         end
         DONE: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decode straight from state so reset clears them asynchronously.
   assign bus.read_o    = (state_q == RD);
   assign bus.write_o   = (state_q == WR);
   assign bus.resp_o    = (state_q == DONE);
   assign bus.address_o = addr_q;
   assign bus.line_o    = line_q;
   assign bus.burst_o   = (state_q == WR) ? buf_q[cnt_q] : '0;

   a_no_dual_request: assert property (
      @(posedge clk) disable iff (!rst_n)
      !(state_q == IDLE && bus.read_i && bus.write_i)
   );

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: reads, writes, gapped beats, spurious strobes and mid-burst reset.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cacheline_adaptor;
   import mem_types_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int n_chk = 0;
   int n_err = 0;
   logic [255:0] last_line;

   cacheline_adaptor_if bus();

   cacheline_adaptor dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_addr,
                          input logic [255:0] ln, input logic [15:0] pat, input int plen);
      int bi = 0;
      bus.address_i = addr;
      bus.read_i    = 1'b1;
      @(negedge clk);
      check({tag, "_read_o"}, bus.read_o, 1'b1);
      check({tag, "_addr"}, bus.address_o, exp_addr);
      bus.address_i = ~addr;
      for (int i = 0; i < plen; i++) begin
         bus.resp_i  = pat[i];
         bus.burst_i = pat[i] ? ln[bi*64 +: 64] : 64'hBAD0_BAD0_BAD0_BAD0;
         @(negedge clk);
         if (pat[i]) bi++;
         if (bi < 4) check($sformatf("%s_busy%0d", tag, i), {bus.resp_o, bus.read_o}, 2'b01);
      end
      bus.resp_i  = 1'b0;
      bus.burst_i = '0;
      check({tag, "_done"}, {bus.resp_o, bus.read_o}, 2'b10);
      check({tag, "_line"}, bus.line_o, ln);
      check({tag, "_addr_hold"}, bus.address_o, exp_addr);
      bus.read_i = 1'b0;
      @(negedge clk);
      check({tag, "_resp_once"}, bus.resp_o, 1'b0);
      check({tag, "_line_hold"}, bus.line_o, ln);
      last_line = ln;
   endtask

   task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] exp_addr,
                           input logic [255:0] ln, input logic [15:0] pat, input int plen);
      int bi = 0;
      bus.address_i = addr;
      bus.line_i    = ln;
      bus.write_i   = 1'b1;
      @(negedge clk);
      check({tag, "_write_o"}, bus.write_o, 1'b1);
      check({tag, "_addr"}, bus.address_o, exp_addr);
      bus.address_i = ~addr;
      bus.line_i    = ~ln;
      for (int i = 0; i < plen; i++) begin
         check($sformatf("%s_beat%0d", tag, i), bus.burst_o, ln[bi*64 +: 64]);
         bus.resp_i = pat[i];
         @(negedge clk);
         if (pat[i]) bi++;
         if (bi < 4) check($sformatf("%s_busy%0d", tag, i), {bus.resp_o, bus.write_o}, 2'b01);
      end
      bus.resp_i = 1'b0;
      check({tag, "_done"}, {bus.resp_o, bus.write_o}, 2'b10);
      check({tag, "_burst_idle"}, bus.burst_o, 64'h0);
      check({tag, "_line_kept"}, bus.line_o, last_line);
      bus.write_i = 1'b0;
      @(negedge clk);
      check({tag, "_resp_once"}, bus.resp_o, 1'b0);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.line_i    = '0;
      bus.address_i = '0;
      bus.read_i    = 1'b0;
      bus.write_i   = 1'b0;
      bus.burst_i   = '0;
      bus.resp_i    = 1'b0;
      last_line     = '0;
      repeat (2) @(negedge clk);
      check("rst_ctrl", {bus.read_o, bus.write_o, bus.resp_o}, 3'b000);
      check("rst_addr", bus.address_o, 32'h0);
      check("rst_line", bus.line_o, 256'h0);
      check("rst_burst", bus.burst_o, 64'h0);
      rst_n = 1'b1;
      @(negedge clk);

      do_read("rd_b2b", 32'h0000_1234, 32'h0000_1220,
              {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 16'h000F, 4);

      do_write("wr", 32'h0000_0040, 32'h0000_0040,
               {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 16'h000F, 4);

      do_read("rd_gap", 32'h0000_2345, 32'h0000_2340,
              {64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C,
               64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A}, 16'h0059, 7);

      bus.resp_i  = 1'b1;
      bus.burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check($sformatf("spur_ctrl%0d", i), {bus.read_o, bus.write_o, bus.resp_o}, 3'b000);
         check($sformatf("spur_line%0d", i), bus.line_o, last_line);
         check($sformatf("spur_addr%0d", i), bus.address_o, 32'h0000_2340);
      end
      bus.resp_i  = 1'b0;
      bus.burst_i = '0;
      @(negedge clk);

      bus.address_i = 32'h0000_0300;
      bus.read_i    = 1'b1;
      @(negedge clk);
      bus.resp_i  = 1'b1;
      bus.burst_i = 64'hEEEE_0000_EEEE_0000;
      @(negedge clk);
      bus.burst_i = 64'hEEEE_1111_EEEE_1111;
      @(negedge clk);
      check("mid_rd_busy", bus.read_o, 1'b1);
      rst_n       = 1'b0;
      bus.read_i  = 1'b0;
      bus.resp_i  = 1'b0;
      bus.burst_i = '0;
      #1;
      check("mid_rst_ctrl", {bus.read_o, bus.write_o, bus.resp_o}, 3'b000);
      check("mid_rst_addr", bus.address_o, 32'h0);
      check("mid_rst_line", bus.line_o, 256'h0);
      last_line = '0;
      @(negedge clk);
      rst_n = 1'b1;

      do_read("rd_post_rst", 32'h0000_0080, 32'h0000_0080,
              {64'h4, 64'h3, 64'h2, 64'h1}, 16'h000F, 4);

      do_write("wr_gap", 32'h0000_1FFF, 32'h0000_1FE0,
               {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0}, 16'h001B, 5);

      do_read("rd_after_wr", 32'h0000_ABCD, 32'h0000_ABC0,
              {64'h8888_7777_6666_5555, 64'h1234_1234_1234_1234,
               64'h9999_0000_9999_0000, 64'h0000_0000_0000_0001}, 16'h000F, 4);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
